sram_write_arbiter: RTL

Feeds the SRAM controller's program-write port (program_x/program_y/program_data) from two drawing requesters, such as the sprite engine and the HUD/text engine. It arbitrates round-robin into a small FIFO and presents one word per controller write slot. It parks the port on an off-screen address when idle, so that no stale pixel is ever rewritten. On each frame switch it flushes pending words so that nothing lands in the wrong buffer.

---
 rtl/sram_write_arbiter_if.sv | 34 +++
 rtl/sram_write_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/sram_write_arbiter_if.sv
// Requester handshake and SRAM program-write bundle for sram_write_arbiter.
// master = requester/driver side, slave = arbiter side.
interface sram_write_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [9:0]  req0_x;
  logic [9:0]  req0_y;
  logic [15:0] req0_data;
  logic        req1_valid;
  logic        req1_ready;
  logic [9:0]  req1_x;
  logic [9:0]  req1_y;
  logic [15:0] req1_data;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        frame_start;
  logic        busy;
  logic [15:0] drop_count;

  modport master (
    output req0_valid, req0_x, req0_y, req0_data,
    output req1_valid, req1_x, req1_y, req1_data,
    input  req0_ready, req1_ready,
    input  program_x, program_y, program_data, frame_start, busy, drop_count
  );

  modport slave (
    input  req0_valid, req0_x, req0_y, req0_data,
    input  req1_valid, req1_x, req1_y, req1_data,
    output req0_ready, req1_ready,
    output program_x, program_y, program_data, frame_start, busy, drop_count
  );
endinterface

// File: rtl/sram_write_arbiter.sv
// Round-robin two-requester write arbiter feeding the SRAM program-write port.
// Define SRAM_WR_ARB_STATS_EN to build the saturating flush drop counter.
module sram_write_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [9:0]  PARK_X     = 10'd1023
) (
  input  logic                sram_clk,
  input  logic                reset,
  input  logic                frame_clk,
  sram_write_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] data;
  } word_t;

  localparam word_t PARK_WORD = '{x: PARK_X, y: 10'd0, data: 16'd0};

  word_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic [1:0]       phase;
  logic             frame_clk_delayed, frame_edge;
  logic             last_grant;
  word_t            out_word;
  logic             out_valid;
  logic             frame_start_q;

  logic  full, empty, grant0, grant1, accept_ok, ready0, ready1, push, commit, pop;
  word_t push_word;

  always_comb begin
    full      = (count == FULL_COUNT);
    empty     = (count == '0);
    // last_grant==1 means req1 went last, so req0 wins a tie
    grant0    = bus.req0_valid & (~bus.req1_valid | last_grant);
    grant1    = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    accept_ok = ~full & ~frame_edge & ~reset;
    ready0    = grant0 & accept_ok;
    ready1    = grant1 & accept_ok;
    push      = ready0 | ready1;
    push_word = ready0 ? word_t'{bus.req0_x, bus.req0_y, bus.req0_data}
                       : word_t'{bus.req1_x, bus.req1_y, bus.req1_data};
    commit    = phase[0];
    pop       = commit & ~empty & ~frame_edge;
  end

  always_ff @(posedge sram_clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge sram_clk) begin
    if (reset) begin
      phase             <= 2'd0;
      frame_clk_delayed <= 1'b0;
      frame_edge        <= 1'b0;
      frame_start_q     <= 1'b0;
      last_grant        <= 1'b1;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      out_word          <= PARK_WORD;
      out_valid         <= 1'b0;
    end else begin
      phase             <= phase + 2'd1;
      frame_clk_delayed <= frame_clk;
      frame_edge        <= frame_clk & ~frame_clk_delayed;
      frame_start_q     <= frame_edge;
      if (frame_edge) begin
        // flush: nothing queued for the old buffer may reach the new one
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        out_word  <= PARK_WORD;
        out_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr     <= wr_ptr + 1'b1;
          last_grant <= ready1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (commit) begin
          out_word  <= pop ? mem[rd_ptr] : PARK_WORD;
          out_valid <= pop;
        end
        count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
  end

`ifdef SRAM_WR_ARB_STATS_EN
  logic [15:0] drop_count_q;
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_count_q} + 17'(count) + 17'(out_valid);

  always_ff @(posedge sram_clk) begin
    if (reset)           drop_count_q <= 16'd0;
    else if (frame_edge) drop_count_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  assign bus.drop_count = drop_count_q;
`else
  assign bus.drop_count = 16'd0;
`endif

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.program_x    = out_word.x;
  assign bus.program_y    = out_word.y;
  assign bus.program_data = out_word.data;
  assign bus.frame_start  = frame_start_q;
  assign bus.busy         = (count != '0) | out_valid;
endmodule
